// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS-lite main controller and its datapath.
//   master : controller side; drives every datapath enable/mux select, the debug
//            state and retired count; receives op and mem_ready.
//   slave  : datapath side; mirror image of master.
interface mips_multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       op;
    logic             mem_ready;
    logic             pcwrite;
    logic             pcwritecond;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             memtoreg;
    logic             regdst;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic             aluop1;
    logic             aluop0;
    logic [1:0]       pcsource;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
               regdst, regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource,
               illegal_op, state, retired
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
               regdst, regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource,
               illegal_op, state, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-lite datapath.
// Ports:
//   clk   : system clock, rising edge.
//   rst_n : asynchronous active-low reset; forces state RST, retired = 0.
//   bus   : mips_multicycle_ctrl_if.master -- opcode and memory-ready in, all
//           datapath controls, illegal_op pulse, debug state and retired count out.
// Control outputs are registered from the next state (Moore); only irwrite/pcwrite
// in FETCH (gated by mem_ready) and the illegal_op pulse in DECODE are combinational.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        StRst    = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StRExe   = 4'd7,
        StRWb    = 4'd8,
        StBeq    = 4'd9,
        StJmp    = 4'd10
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef struct packed {
        logic       fetch;    // qualifies irwrite/pcwrite with mem_ready
        logic       jmp_pcw;  // unconditional pcwrite in JMP
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

    // Kept as a raw 4-bit register so the unused codes 11..15 remain recoverable.
    logic [3:0]       r_state;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_retired;
    logic [3:0]       w_next;
    logic             w_retire;
    logic             w_illegal;

    function automatic ctrl_t decode_ctrl(input logic [3:0] s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.fetch   = 1'b1;
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
            end
            StDecode: c.alusrcb = 2'b11;
            StMemAdr: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            StMemRd: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            StMemWb: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            StMemWr: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            StRExe: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            StRWb: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            StBeq: begin
                c.alusrca     = 1'b1;
                c.aluop       = 2'b01;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
            end
            StJmp: begin
                c.jmp_pcw  = 1'b1;
                c.pcsource = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next    = StFetch;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            StRst:    w_next = StFetch;
            StFetch:  w_next = bus.mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (bus.op)
                    OpRtype:    w_next = StRExe;
                    OpLw, OpSw: w_next = StMemAdr;
                    OpBeq:      w_next = StBeq;
                    OpJ:        w_next = StJmp;
                    default: begin
                        w_next    = StFetch;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr: w_next = (bus.op == OpLw) ? StMemRd : StMemWr;
            StMemRd:  w_next = bus.mem_ready ? StMemWb : StMemRd;
            StMemWr: begin
                w_next   = bus.mem_ready ? StFetch : StMemWr;
                w_retire = bus.mem_ready;
            end
            StRExe:   w_next = StRWb;
            StMemWb, StRWb, StBeq, StJmp: begin
                w_next   = StFetch;
                w_retire = 1'b1;
            end
            default:  w_next = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StRst;
            r_ctrl    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_ctrl(w_next);
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign bus.irwrite     = r_ctrl.fetch & bus.mem_ready;
    assign bus.pcwrite     = r_ctrl.jmp_pcw | (r_ctrl.fetch & bus.mem_ready);
    assign bus.pcwritecond = r_ctrl.pcwritecond;
    assign bus.iord        = r_ctrl.iord;
    assign bus.memread     = r_ctrl.memread;
    assign bus.memwrite    = r_ctrl.memwrite;
    assign bus.memtoreg    = r_ctrl.memtoreg;
    assign bus.regdst      = r_ctrl.regdst;
    assign bus.regwrite    = r_ctrl.regwrite;
    assign bus.alusrca     = r_ctrl.alusrca;
    assign bus.alusrcb     = r_ctrl.alusrcb;
    assign bus.aluop1      = r_ctrl.aluop[1];
    assign bus.aluop0      = r_ctrl.aluop[0];
    assign bus.pcsource    = r_ctrl.pcsource;
    assign bus.illegal_op  = w_illegal;
    assign bus.state       = r_state;
    assign bus.retired     = r_retired;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one 16-bit-counter instance for the
// instruction flows and one 2-bit-counter instance for the retired-count wrap.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_b_n;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   t_start;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(16)) ifa ();
    mips_multicycle_ctrl_if #(.CNT_W(2))  ifb ();

    mips_multicycle_ctrl #(.CNT_W(16)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    mips_multicycle_ctrl #(.CNT_W(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (ifb)
    );

    logic [16:0] all_a;
    assign all_a = {ifa.pcwrite, ifa.pcwritecond, ifa.iord, ifa.memread, ifa.memwrite,
                    ifa.irwrite, ifa.memtoreg, ifa.regdst, ifa.regwrite, ifa.alusrca,
                    ifa.alusrcb, ifa.aluop1, ifa.aluop0, ifa.pcsource, ifa.illegal_op};

    logic [1:0] aluop_a;
    assign aluop_a = {ifa.aluop1, ifa.aluop0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [1:0] wrap_exp [5];
        wrap_exp[0] = 2'd1;
        wrap_exp[1] = 2'd2;
        wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0;
        wrap_exp[4] = 2'd1;

        rst_n         = 1'b0;
        rst_b_n       = 1'b0;
        ifa.op        = 6'b000000;
        ifa.mem_ready = 1'b1;
        ifb.op        = 6'b101011;
        ifb.mem_ready = 1'b1;
        #12;
        chk("reset_state", ifa.state, 0);
        chk("reset_outputs", all_a, 0);
        chk("reset_retired", ifa.retired, 0);

        // R-type: 0 -> 1 -> 2 -> 7 -> 8 -> 1
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rt_fetch_state", ifa.state, 1);
        chk("rt_fetch_memread", ifa.memread, 1);
        chk("rt_fetch_alusrcb", ifa.alusrcb, 2'b01);
        chk("rt_fetch_irwrite", ifa.irwrite, 1);
        chk("rt_fetch_pcwrite", ifa.pcwrite, 1);
        tick();
        chk("rt_decode_state", ifa.state, 2);
        chk("rt_decode_alusrcb", ifa.alusrcb, 2'b11);
        tick();
        chk("rt_rexe_state", ifa.state, 7);
        chk("rt_rexe_aluop", aluop_a, 2'b10);
        chk("rt_rexe_alusrca", ifa.alusrca, 1);
        tick();
        chk("rt_rwb_state", ifa.state, 8);
        chk("rt_rwb_regwrite", ifa.regwrite, 1);
        chk("rt_rwb_regdst", ifa.regdst, 1);
        tick();
        chk("rt_back_fetch", ifa.state, 1);
        chk("rt_retired", ifa.retired, 1);

        // lw with three not-ready cycles in MEMRD
        t_start = cyc;
        ifa.op  = 6'b100011;
        tick();
        chk("lw_decode", ifa.state, 2);
        tick();
        chk("lw_memadr", ifa.state, 3);
        chk("lw_memadr_alusrcb", ifa.alusrcb, 2'b10);
        ifa.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lw_memrd_state", ifa.state, 4);
            chk("lw_memrd_memread", ifa.memread, 1);
            chk("lw_memrd_iord", ifa.iord, 1);
        end
        ifa.mem_ready = 1'b1;
        tick();
        chk("lw_memwb_state", ifa.state, 5);
        chk("lw_memwb_ctl", {ifa.regwrite, ifa.memtoreg, ifa.regdst}, 3'b110);
        ifa.mem_ready = 1'b0;
        tick();
        chk("lw_back_fetch", ifa.state, 1);
        chk("lw_cycles", cyc - t_start, 8);
        chk("lw_retired", ifa.retired, 2);

        // FETCH stall: two not-ready cycles, then ready
        chk("stall1_irwrite", ifa.irwrite, 0);
        chk("stall1_pcwrite", ifa.pcwrite, 0);
        ifa.op = 6'b000100;
        tick();
        chk("stall2_state", ifa.state, 1);
        chk("stall2_irwrite", ifa.irwrite, 0);
        ifa.mem_ready = 1'b1;
        #1;
        chk("ready_irwrite", ifa.irwrite, 1);
        chk("ready_pcwrite", ifa.pcwrite, 1);

        // beq then j
        tick();
        chk("beq_decode", ifa.state, 2);
        tick();
        chk("beq_state", ifa.state, 9);
        chk("beq_aluop", aluop_a, 2'b01);
        chk("beq_pcwritecond", ifa.pcwritecond, 1);
        chk("beq_pcsource", ifa.pcsource, 2'b01);
        ifa.op = 6'b000010;
        tick();
        chk("beq_back_fetch", ifa.state, 1);
        tick();
        tick();
        chk("j_state", ifa.state, 10);
        chk("j_pcwrite", ifa.pcwrite, 1);
        chk("j_pcsource", ifa.pcsource, 2'b10);
        tick();
        chk("j_retired", ifa.retired, 4);

        // illegal opcode
        ifa.op = 6'b111111;
        tick();
        chk("ill_decode", ifa.state, 2);
        chk("ill_pulse", ifa.illegal_op, 1);
        tick();
        chk("ill_fetch", ifa.state, 1);
        chk("ill_pulse_gone", ifa.illegal_op, 0);
        chk("ill_retired", ifa.retired, 4);

        // reset during a stalled MEMWR
        ifa.op = 6'b101011;
        tick();
        tick();
        ifa.mem_ready = 1'b0;
        tick();
        chk("sw_memwr_state", ifa.state, 6);
        chk("sw_memwr_memwrite", ifa.memwrite, 1);
        tick();
        chk("sw_memwr_hold", ifa.state, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", ifa.state, 0);
        chk("arst_outputs", all_a, 0);
        chk("arst_retired", ifa.retired, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        ifa.mem_ready = 1'b1;
        ifa.op        = 6'b000000;
        tick();
        chk("arst_restart_fetch", ifa.state, 1);

        // 2-bit counter wrap across five sw instructions
        @(negedge clk);
        rst_b_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            repeat (4) tick();
            chk("wrap_state", ifb.state, 1);
            chk("wrap_retired", ifb.retired, wrap_exp[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
